// File: rtl/permute_sequencer.sv
// Address and round sequencer for the 5x5-lane permutation: row-major read
// addressing, LAT-delayed write addressing, and round-level hazard hold-off.
module permute_sequencer #(
    parameter int ROUNDS = 24,
    parameter int LAT    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic       ready,
    output logic       busy,
    output logic       rdEn,
    output logic [2:0] rdX,
    output logic [2:0] rdY,
    output logic [4:0] round,
    output logic       wrEn,
    output logic [2:0] wrX,
    output logic [2:0] wrY,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);
    localparam logic [2:0] WAIT_LAST  = 3'(LAT - 1);

    state_t     state;
    logic [2:0] x;
    logic [2:0] y;
    logic [4:0] round_q;
    logic [2:0] wcnt;
    logic [6:0] wr_pipe [LAT];

    // Stall is the only input allowed to reach an output combinationally.
    assign rdEn  = (state == READ) && !stall;
    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign rdX   = x;
    assign rdY   = y;
    assign round = round_q;
    assign {wrEn, wrX, wrY} = wr_pipe[LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            x       <= 3'd0;
            y       <= 3'd0;
            round_q <= 5'd0;
            wcnt    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x       <= 3'd0;
                        y       <= 3'd0;
                        round_q <= 5'd0;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (!stall) begin
                        if (x == 3'd4) begin
                            x <= 3'd0;
                            if (y == 3'd4) begin
                                y     <= 3'd0;
                                wcnt  <= 3'd0;
                                state <= WAIT;
                            end else begin
                                y <= y + 3'd1;
                            end
                        end else begin
                            x <= x + 3'd1;
                        end
                    end
                end
                WAIT: begin
                    // Hold until the round's last write has drained from the pipe.
                    if (wcnt == WAIT_LAST) begin
                        if (round_q == LAST_ROUND) begin
                            state <= DONE;
                        end else begin
                            round_q <= round_q + 5'd1;
                            state   <= READ;
                        end
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-address pipe: shifts every cycle, so stalls appear as wrEn bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                wr_pipe[i] <= 7'd0;
            end
        end else begin
            wr_pipe[0] <= {rdEn, x, y};
            for (int i = 1; i < LAT; i++) begin
                wr_pipe[i] <= wr_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_permute_sequencer.sv
// Bench for permute_sequencer: default and small-parameter instances checked
// cycle by cycle against a schedule model built from the round/stall rules.
module tb_permute_sequencer;

    localparam int MAXC = 1500;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       rdEn;
        logic [2:0] rdX;
        logic [2:0] rdY;
        logic [4:0] round;
        logic       wrEn;
        logic [2:0] wrX;
        logic [2:0] wrY;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_b = 1'b0, stall_b = 1'b0;
    logic start_s = 1'b0, stall_s = 1'b0;

    logic       ready_b, busy_b, rdEn_b, wrEn_b, done_b;
    logic [2:0] rdX_b, rdY_b, wrX_b, wrY_b;
    logic [4:0] round_b;
    logic       ready_s, busy_s, rdEn_s, wrEn_s, done_s;
    logic [2:0] rdX_s, rdY_s, wrX_s, wrY_s;
    logic [4:0] round_s;

    obs_t obs_b, obs_s;
    assign obs_b = {ready_b, busy_b, rdEn_b, rdX_b, rdY_b, round_b, wrEn_b, wrX_b, wrY_b, done_b};
    assign obs_s = {ready_s, busy_s, rdEn_s, rdX_s, rdY_s, round_s, wrEn_s, wrX_s, wrY_s, done_s};

    int n_tests = 0;
    int n_fail  = 0;

    logic       start_tab [MAXC];
    logic       stall_tab [MAXC];
    logic [6:0] exp_rd    [MAXC];
    logic [4:0] exp_round [MAXC];
    logic [2:0] exp_stat  [MAXC];

    always #5 clk = ~clk;

    permute_sequencer u_big (
        .clk(clk), .rst(rst), .start(start_b), .stall(stall_b),
        .ready(ready_b), .busy(busy_b), .rdEn(rdEn_b), .rdX(rdX_b), .rdY(rdY_b),
        .round(round_b), .wrEn(wrEn_b), .wrX(wrX_b), .wrY(wrY_b), .done(done_b)
    );

    permute_sequencer #(.ROUNDS(2), .LAT(1)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .stall(stall_s),
        .ready(ready_s), .busy(busy_s), .rdEn(rdEn_s), .rdX(rdX_s), .rdY(rdY_s),
        .round(round_s), .wrEn(wrEn_s), .wrX(wrX_s), .wrY(wrY_s), .done(done_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic st, input logic sl);
        if (sel == 0) begin
            start_b = st;
            stall_b = sl;
        end else begin
            start_s = st;
            stall_s = sl;
        end
    endtask

    task automatic clear_tabs();
        for (int c = 0; c < MAXC; c++) begin
            start_tab[c] = 1'b0;
            stall_tab[c] = 1'b0;
        end
    endtask

    task automatic put(input int c, input logic [6:0] rd, input int r, input logic [2:0] st);
        if (c < MAXC) begin
            exp_rd[c]    = rd;
            exp_round[c] = 5'(r);
            exp_stat[c]  = st;
        end
    endtask

    // Schedule model: status encoded {ready, busy, done}; reads in row-major
    // order with x fastest, each stalled cycle re-presenting the pending lane.
    task automatic build_model(input int rounds, input int lat, output int done_c, output int rchg);
        int c;
        c    = 1;
        rchg = -1;
        for (int r = 0; r < rounds; r++) begin
            for (int k = 0; k < 25; k++) begin
                while (stall_tab[c] && c < MAXC - 8) begin
                    put(c, {1'b0, 3'(k % 5), 3'(k / 5)}, r, 3'b010);
                    c++;
                end
                put(c, {1'b1, 3'(k % 5), 3'(k / 5)}, r, 3'b010);
                c++;
            end
            for (int w = 0; w < lat; w++) begin
                put(c, 7'd0, r, 3'b010);
                c++;
            end
            if (r == 0) rchg = c;
        end
        put(c, 7'd0, rounds - 1, 3'b011);
        done_c = c;
        c++;
        while (c < MAXC) begin
            put(c, 7'd0, rounds - 1, 3'b100);
            c++;
        end
    endtask

    task automatic check_idle_after_reset(input int sel, input string tag);
        obs_t o;
        o = (sel != 0) ? obs_s : obs_b;
        check({tag, "_stat"}, {o.ready, o.busy, o.done}, 3'b100);
        check({tag, "_rd"}, {o.rdEn, o.rdX, o.rdY}, 7'd0);
        check({tag, "_wr"}, {o.wrEn, o.wrX, o.wrY}, 7'd0);
        check({tag, "_round"}, o.round, 5'd0);
    endtask

    task automatic reset_seq(input int sel);
        #2 rst = 1'b0;
        #1 check_idle_after_reset(sel, "abort_now");
        @(posedge clk);
        #1 set_in(sel, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_after_reset(sel, $sformatf("abort_after%0d", i));
        end
    endtask

    task automatic run(input int sel, input int abort_c, input int fixed_done, input bit rand_start);
        int   rounds, lat, done_c, rchg, ncyc;
        int   nrd, nwr, ndone, done_at, first_rd, last_rd, obs_rchg;
        obs_t o;
        logic [6:0] wr_o;
        logic [6:0] rd_hist [MAXC];
        rounds = (sel != 0) ? 2 : 24;
        lat    = (sel != 0) ? 1 : 2;
        build_model(rounds, lat, done_c, rchg);
        if (rand_start) begin
            for (int c = 1; c <= done_c; c++) start_tab[c] = ($urandom_range(0, 19) == 0);
        end
        ncyc = done_c + 3;
        nrd = 0; nwr = 0; ndone = 0; done_at = -1;
        first_rd = -1; last_rd = -1; obs_rchg = -1;
        @(negedge clk);
        set_in(sel, 1'b1, 1'b0);
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            #1 set_in(sel, start_tab[c], stall_tab[c]);
            @(negedge clk);
            o          = (sel != 0) ? obs_s : obs_b;
            wr_o       = {o.wrEn, o.wrX, o.wrY};
            rd_hist[c] = {o.rdEn, o.rdX, o.rdY};
            check($sformatf("rd@%0d", c), rd_hist[c], exp_rd[c]);
            check($sformatf("wr@%0d", c), wr_o, (c > lat) ? exp_rd[c-lat] : 7'd0);
            if (c > lat) check($sformatf("align@%0d", c), wr_o, rd_hist[c-lat]);
            check($sformatf("round@%0d", c), o.round, exp_round[c]);
            check($sformatf("status@%0d", c), {o.ready, o.busy, o.done}, exp_stat[c]);
            if (o.rdEn) begin
                nrd++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (o.wrEn) nwr++;
            if (o.done) begin
                ndone++;
                done_at = c;
            end
            if (obs_rchg < 0 && o.round == 5'd1) obs_rchg = c;
            if (c == abort_c) begin
                reset_seq(sel);
                return;
            end
            @(posedge clk);
        end
        #1 set_in(sel, 1'b0, 1'b0);
        check("read_count", nrd, 25 * rounds);
        check("write_count", nwr, 25 * rounds);
        check("done_count", ndone, 1);
        check("done_cycle", done_at, done_c);
        check("round1_cycle", obs_rchg, rchg);
        check("first_read", first_rd, 1);
        if (fixed_done > 0) begin
            check("done_cycle_fixed", done_at, fixed_done);
            check("last_read_fixed", last_rd, fixed_done - lat - 1);
        end
    endtask

    initial begin
        clear_tabs();
        #3;
        check_idle_after_reset(0, "por_big");
        check_idle_after_reset(1, "por_small");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Plain default run.
        clear_tabs();
        run(0, -1, 649, 1'b0);

        // Starts during READ, WAIT and DONE are ignored, then a fresh run.
        clear_tabs();
        start_tab[10]  = 1'b1;
        start_tab[26]  = 1'b1;
        start_tab[649] = 1'b1;
        run(0, -1, 649, 1'b0);
        clear_tabs();
        run(0, -1, 649, 1'b0);

        // Five-cycle stall at round 0, lane (3,2).
        clear_tabs();
        for (int c = 14; c <= 18; c++) stall_tab[c] = 1'b1;
        run(0, -1, 654, 1'b0);

        // Reset mid-READ at round 3, lane (2,1).
        clear_tabs();
        run(0, 89, 0, 1'b0);
        repeat (2) @(negedge clk);

        // Random stalls and stray start pulses.
        for (int k = 0; k < 2; k++) begin
            clear_tabs();
            for (int c = 1; c < 700; c++) stall_tab[c] = ($urandom_range(0, 9) == 0);
            run(0, -1, 0, 1'b1);
        end

        // Small instance: ROUNDS=2, LAT=1.
        clear_tabs();
        run(1, -1, 53, 1'b0);
        check("small_round_change", 27, 25 + 1 + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/permute_sequencer.md
# permute_sequencer

Address and round sequencer for the permutation function. On `start` it runs `ROUNDS` rounds over the 5x5 lane array, issuing read addresses in row-major order, regenerating the matching write addresses `LAT` cycles later, and holding off each new round until every write of the previous round has retired. It sits upstream of the lane memory and round-constant logic and supplies the datapath's round index.

## Interface
- `ROUNDS`, 24, number of rounds per permutation (2..31)
- `LAT`, 2, read-to-write datapath latency in cycles (1..7)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a permutation; sampled only in IDLE
- `stall`  in  1  pause read issue while in READ
- `ready`  out  1  high only in IDLE
- `busy`  out  1  high in READ, WAIT, DONE
- `rdEn`  out  1  read strobe
- `rdX`, `rdY`  out  3 each  read lane coordinates, 0..4
- `round`  out  5  current round index, 0..ROUNDS-1
- `wrEn`  out  1  write strobe, `rdEn` delayed `LAT` cycles
- `wrX`, `wrY`  out  3 each  write coordinates, `rdX`/`rdY` delayed `LAT` cycles
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, WAIT, DONE.
- IDLE: `ready`=1. `start`=1 loads x=0, y=0, round=0 and moves to READ.
- READ, `stall`=0:
  - `rdEn`=1 and (x,y) advances.
  - x increments and wraps 4->0; on wrap, y increments.
  - At (4,4), the state moves to WAIT with the wait counter cleared; x and y return to 0.
- READ, `stall`=1: `rdEn`=0, x/y/round hold, and the write pipeline keeps shifting, inserting a bubble.
- WAIT: counts exactly `LAT` cycles with `rdEn`=0. At the end:
  - if round = ROUNDS-1, go to DONE;
  - otherwise increment round and go to READ.
- DONE: `done`=1 for one cycle, then IDLE. round holds its last value until the next `start`.
- Write pipeline: a `LAT`-deep shift register of {rdEn, rdX, rdY}. It runs in every state and is cleared only by reset.
- `start` outside IDLE is ignored. `stall` outside READ is ignored.
- x and y never take values 5..7. round never reaches ROUNDS.

## Timing
- Reset (`rst`=0), asynchronous, takes effect immediately:
  - state IDLE, with `ready`=1 and `busy`=0;
  - `rdEn`, `wrEn`, `done` = 0;
  - all coordinates and `round` = 0;
  - pipeline contents cleared.
- Reset mid-operation aborts with no `done` pulse and no pending writes.
- Cycle numbering: `start` is sampled at edge 0. The first READ cycle is cycle 1. All outputs are decoded from registers, with no combinational path from inputs to outputs except `stall`->`rdEn`.
- Without stall, each round takes 25 READ cycles plus `LAT` WAIT cycles.
  - Round r reads occupy cycles r*(25+LAT)+1 .. r*(25+LAT)+25.
  - The last write of each round lands in its final WAIT cycle, so the next round's first read follows that write.
- `done` is high in cycle ROUNDS*(25+LAT)+1, which is 649 at the defaults. `ready` returns the cycle after.
- Each stalled cycle delays all later events by one cycle.
- A `start` held high during DONE is not accepted. A new permutation begins only from a `start` sampled in IDLE.

## Test plan
- **Reset values.** Assert `rst`=0 mid-READ at round 3, (2,1). Require all outputs zero except `ready`=1, no `done`, and `wrEn`=0 on the cycle after release.
- **Full run at defaults.** Pulse `start`. Require:
  - exactly 600 `rdEn` and 600 `wrEn` cycles;
  - first read (0,0) at cycle 1, last read (4,4) of round 23 at cycle 646;
  - `done` only at cycle 649.
- **Write alignment.** Require `wrEn`/`wrX`/`wrY` to equal `rdEn`/`rdX`/`rdY` delayed 2 cycles throughout the run. Require that no read of round r+1 occurs before the last write of round r.
- **Stall.** Hold `stall` high for 5 cycles at round 0, (3,2). Require:
  - `rdEn`=0 and coordinates held during the stall;
  - matching `wrEn` bubbles 2 cycles later;
  - `done` at cycle 654.
- **Ignored start.** Pulse `start` during READ, WAIT and DONE. Require no restart and `done` still at cycle 649. Then start again from IDLE and require a fresh run with `round`=0.
- **Parameters.** Use ROUNDS=2, LAT=1. Require 50 reads, round changing 0->1 at cycle 27, and `done` at cycle 53.
